// File: rtl/clocks_gen_pkg.sv
// clocks_gen_pkg: default frequencies and half-period helper for the stopwatch clock dividers
package clocks_gen_pkg;
  localparam int SYS_CLK_HZ_DEF = 100_000_000;
  localparam int ONEHZ_HZ_DEF = 1;
  localparam int TWOHZ_HZ_DEF = 2;
  localparam int FAST_HZ_DEF = 500;
  localparam int BLINK_HZ_DEF = 4;
  // Returns 0 for f == 0, so the elaboration check rejects it instead of dividing by zero.
  function automatic int half_count(input int sys_hz, input int f);
    return (f > 0) ? sys_hz / (2 * f) : 0;
  endfunction
endpackage

// File: rtl/clk_div.sv
// clk_div: toggle divider producing a square wave with HALF cycles high and HALF cycles low
module clk_div #(
  parameter int HALF = 1
) (
  input  logic sys_clk,
  input  logic rst,
  output logic clk_out
);
  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] LAST = W'(HALF - 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic out_q, out_d;
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    out_d = (cnt_q == LAST) ? ~out_q : out_q;
  end
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  assign clk_out = out_q;
endmodule

// File: rtl/clocks_gen.sv
// clocks_gen: derives the stopwatch 1 Hz, 2 Hz, display-mux and blink square waves from sys_clk
// Define CLOCKS_GEN_BLINK_EN to build the blink divider; otherwise blink_clk is tied to 0.
module clocks_gen
  import clocks_gen_pkg::*;
#(
  parameter int SYS_CLK_HZ = SYS_CLK_HZ_DEF,
  parameter int ONEHZ_HZ = ONEHZ_HZ_DEF,
  parameter int TWOHZ_HZ = TWOHZ_HZ_DEF,
  parameter int FAST_HZ = FAST_HZ_DEF,
  parameter int BLINK_HZ = BLINK_HZ_DEF
) (
  input  logic sys_clk,
  input  logic rst,
  output logic onehz_clk,
  output logic twohz_clk,
  output logic fast_clk,
  output logic blink_clk
);
  localparam int ONEHZ_HALF = half_count(SYS_CLK_HZ, ONEHZ_HZ);
  localparam int TWOHZ_HALF = half_count(SYS_CLK_HZ, TWOHZ_HZ);
  localparam int FAST_HALF = half_count(SYS_CLK_HZ, FAST_HZ);
  localparam int BLINK_HALF = half_count(SYS_CLK_HZ, BLINK_HZ);
  if (ONEHZ_HALF < 1 || TWOHZ_HALF < 1 || FAST_HALF < 1 || BLINK_HALF < 1) begin : g_bad_freq
    $error("clocks_gen: every frequency must be nonzero and at most SYS_CLK_HZ/2");
  end
  clk_div #(.HALF(ONEHZ_HALF)) u_onehz (.sys_clk(sys_clk), .rst(rst), .clk_out(onehz_clk));
  clk_div #(.HALF(TWOHZ_HALF)) u_twohz (.sys_clk(sys_clk), .rst(rst), .clk_out(twohz_clk));
  clk_div #(.HALF(FAST_HALF)) u_fast (.sys_clk(sys_clk), .rst(rst), .clk_out(fast_clk));
`ifdef CLOCKS_GEN_BLINK_EN
  clk_div #(.HALF(BLINK_HALF)) u_blink (.sys_clk(sys_clk), .rst(rst), .clk_out(blink_clk));
`else
  assign blink_clk = 1'b0;
`endif
endmodule

// File: tb/tb_clocks_gen.sv
// tb_clocks_gen: directed checks of clocks_gen with reduced frequencies (HALF = 500/250/5/125)
module tb_clocks_gen;
  logic clk, rst;
  logic onehz_clk, twohz_clk, fast_clk, blink_clk;
  logic [3:0] v, p, acc;
  int n_cmp = 0, n_bad = 0;
  int rise[4], fall[4], last[4], ntog[4], badiv[4];
  int align_bad;
  int halfs[4] = '{500, 250, 5, 125};
`ifdef CLOCKS_GEN_BLINK_EN
  localparam int BLINK_RISE = 125, BLINK_TOG = 32;
`else
  localparam int BLINK_RISE = -1, BLINK_TOG = 0;
`endif
  clocks_gen #(
    .SYS_CLK_HZ(1000), .ONEHZ_HZ(1), .TWOHZ_HZ(2), .FAST_HZ(100), .BLINK_HZ(4)
  ) dut (
    .sys_clk(clk), .rst(rst), .onehz_clk(onehz_clk), .twohz_clk(twohz_clk),
    .fast_clk(fast_clk), .blink_clk(blink_clk)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] outs;
    return {blink_clk, fast_clk, twohz_clk, onehz_clk};
  endfunction
  // Edge numbers count from 1 at the first edge sampling rst high.
  task automatic measure(input int n);
    for (int k = 0; k < 4; k++) begin
      rise[k] = -1; fall[k] = -1; last[k] = 0; ntog[k] = 0; badiv[k] = 0;
    end
    align_bad = 0;
    p = outs();
    for (int e = 1; e <= n; e++) begin
      tick();
      v = outs();
      for (int k = 0; k < 4; k++) begin
        if (v[k] != p[k]) begin
          if (v[k] && rise[k] < 0) rise[k] = e;
          if (!v[k] && fall[k] < 0) fall[k] = e;
          if (e - last[k] != halfs[k]) badiv[k]++;
          last[k] = e;
          ntog[k]++;
        end
      end
      if (v[0] != p[0] && v[1] == p[1]) align_bad++;
      p = v;
    end
  endtask
  initial begin
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      acc |= outs();
    end
    check("hold_onehz", int'(acc[0]), 0);
    check("hold_twohz", int'(acc[1]), 0);
    check("hold_fast", int'(acc[2]), 0);
    check("hold_blink", int'(acc[3]), 0);
    rst = 1'b1;
    measure(4000);
    check("fast_rise", rise[2], 5);
    check("fast_fall", fall[2], 10);
    check("blink_rise", rise[3], BLINK_RISE);
    check("twohz_rise", rise[1], 250);
    check("onehz_rise", rise[0], 500);
    check("onehz_fall", fall[0], 1000);
    check("onehz_tog", ntog[0], 8);
    check("twohz_tog", ntog[1], 16);
    check("fast_tog", ntog[2], 800);
    check("blink_tog", ntog[3], BLINK_TOG);
    check("onehz_phase", badiv[0], 0);
    check("twohz_phase", badiv[1], 0);
    check("fast_phase", badiv[2], 0);
    check("blink_phase", badiv[3], 0);
    check("align", align_bad, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (336) tick();
    check("pre_rst_fast", int'(fast_clk), 1);
    check("pre_rst_twohz", int'(twohz_clk), 1);
    rst = 1'b0;
    tick();
    check("mid_rst_outs", int'(outs()), 0);
    rst = 1'b1;
    measure(600);
    check("mid_fast_rise", rise[2], 5);
    check("mid_fast_fall", fall[2], 10);
    check("mid_twohz_rise", rise[1], 250);
    check("mid_onehz_rise", rise[0], 500);
    check("mid_blink_rise", rise[3], BLINK_RISE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
